instr_fetcher: RTL
==================

Name: instr_fetcher

Overview:
- Per-core instruction fetch stage that sits directly upstream of core_fsm and produces the fetcher_state that core_fsm consumes.
- On core_state == FETCH it returns the 16-bit instruction at current_pc. The source is a small direct-mapped instruction buffer on a hit, or the program-memory controller via a valid/ready read handshake on a miss.
- The instruction goes to the decoder.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, PC / program address width
- PROGRAM_MEM_DATA_BITS, 16, instruction width
- CACHE_LINES, 4, direct-mapped buffer entries (power of 2, ≥2); index = pc[log2(CACHE_LINES)-1:0], tag = remaining upper pc bits

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- core_state  in  3  core_fsm state: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111
- current_pc  in  PROGRAM_MEM_ADDR_BITS  PC to fetch
- flush  in  1  invalidate all buffer lines (pulsed at kernel launch)
- mem_read_valid  out  1  program-memory read request
- mem_read_address  out  PROGRAM_MEM_ADDR_BITS  request address
- mem_read_ready  in  1  read data valid this cycle
- mem_read_data  in  PROGRAM_MEM_DATA_BITS  returned instruction
- fetcher_state  out  2  IDLE=00, FETCHING=01, FETCHED=10 (11 unused)
- instruction  out  PROGRAM_MEM_DATA_BITS  fetched instruction, stable while FETCHED
- hit_count  out  16  buffer hits, saturating at 0xFFFF
- miss_count  out  16  buffer misses, saturating at 0xFFFF

Behaviour:
- All state updates on posedge clk. Reset is synchronous and active-high.
- Reset values: fetcher_state=00, mem_read_valid=0, mem_read_address=0, instruction=0, hit_count=0, miss_count=0, all line valid bits=0.
- IDLE:
  - If core_state==FETCH, look up line[current_pc index].
  - Hit (valid && tag match): next cycle fetcher_state=FETCHED, instruction=line data, hit_count+1. Latency is 1 cycle.
  - Miss: next cycle fetcher_state=FETCHING, mem_read_valid=1, mem_read_address=current_pc, miss_count+1.
  - Any other core_state: stay IDLE with no outputs changing.
- FETCHING:
  - Hold mem_read_valid=1 and mem_read_address constant until a cycle where mem_read_ready=1.
  - On that edge: instruction=mem_read_data; the line at the index is written (data, tag, valid=1); mem_read_valid=0; fetcher_state=FETCHED.
  - Miss latency = memory latency + 1 cycle.
  - mem_read_ready while mem_read_valid=0 is ignored.
  - core_state changes during FETCHING are ignored; the transaction always completes.
- FETCHED:
  - Hold instruction.
  - When core_state==DECODE, go to IDLE next cycle; instruction keeps its value.
  - Stay FETCHED otherwise.
- Exactly one outstanding memory request at most. mem_read_address is only meaningful while mem_read_valid=1.
- flush: all valid bits clear on the next edge; fetcher_state and any in-flight request are unaffected.
  - flush in the same cycle as a fill: flush wins and the line is not marked valid. instruction still captures mem_read_data and the FSM still reaches FETCHED.
  - flush in the same cycle as a hit lookup in IDLE: the lookup uses the pre-flush valid bits, so it counts as a hit.
- A fill on a conflicting index overwrites the old line (no write-back; the buffer is read-only).
- Counters saturate at 0xFFFF and do not wrap. Only reset clears them.
- Reset mid-FETCHING: next edge mem_read_valid=0 and fetcher_state=IDLE. A late mem_read_ready after reset is ignored.
- fetcher_state=11 is unreachable; if entered, go to IDLE next cycle.

Test Plan:
- Cold miss:
  - Stimulus: reset, flush, core_state=FETCH, pc=0x05; memory asserts ready with data 0xA1B2 three cycles after valid.
  - Required: mem_read_valid=1 with address 0x05 for those 3 cycles, then fetcher_state=10, instruction=0xA1B2, miss_count=1.
  - Then core_state=DECODE → fetcher_state=00 next cycle.
- Hit:
  - Stimulus: refetch pc=0x05.
  - Required: fetcher_state=10 one cycle after FETCH, mem_read_valid never asserts, instruction=0xA1B2, hit_count=1.
- Conflict eviction (CACHE_LINES=4):
  - Stimulus: fetch 0x01 (data 0x1111), then 0x05 (data 0x5555), then 0x01 again.
  - Required: three misses, the third returns 0x1111 from memory, miss_count=3.
- Zero-wait memory and flush:
  - Stimulus: mem_read_ready high continuously; pc=0x02 with data 0x2222.
  - Required: FETCHED two cycles after FETCH.
  - Stimulus: flush coincident with that fill, then refetch 0x02.
  - Required: the refetch misses.
- Reset mid-fetch:
  - Stimulus: pc=0x07 with ready withheld; assert reset for 1 cycle during FETCHING; then pulse ready.
  - Required: mem_read_valid=0, fetcher_state=00, instruction=0, counters=0, and the late ready has no effect.
- End-to-end with core_fsm:
  - Stimulus: 4-instruction program ending in RET.
  - Required: core_fsm reaches DONE and done=1; hit_count+miss_count equals the number of FETCH entries.

Source files
------------

// File: rtl/instr_fetcher.sv
// -----------------------------------------------------------------------------
// instr_fetcher
//
// Per-core instruction fetch stage. When the core sits in FETCH, the 16-bit
// instruction at current_pc is returned, either from a small direct-mapped
// instruction buffer (hit, 1-cycle latency) or from program memory through a
// valid/ready read handshake (miss, memory latency + 1 cycle). The resulting
// fetcher_state is consumed by core_fsm; the instruction goes to the decoder.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   core_state        - core_fsm state (FETCH=001 starts a lookup, DECODE=010
//                       releases a FETCHED instruction)
//   current_pc        - PC to fetch
//   flush             - invalidate every buffer line on the next edge
//   mem_read_valid    - program-memory read request (registered)
//   mem_read_address  - request address, meaningful while mem_read_valid=1
//   mem_read_ready    - memory data valid this cycle
//   mem_read_data     - returned instruction
//   fetcher_state     - IDLE=00, FETCHING=01, FETCHED=10
//   instruction       - fetched instruction, held until the next fetch
//   hit_count         - saturating buffer-hit counter
//   miss_count        - saturating buffer-miss counter
// -----------------------------------------------------------------------------
module instr_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [1:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);

  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = PROGRAM_MEM_ADDR_BITS - IDX_W;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FETCHING = 2'b01,
    ST_FETCHED  = 2'b10,
    ST_UNUSED   = 2'b11
  } fetch_state_t;

  // Even parity over a stored line; a line whose parity no longer matches is
  // treated as a miss so a corrupted entry is refetched rather than executed.
  function automatic logic line_parity_f(
    input logic [TAG_W-1:0]                 tag,
    input logic [PROGRAM_MEM_DATA_BITS-1:0] data
  );
    return ^{tag, data};
  endfunction

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  fetch_state_t                     state_r;
  fetch_state_t                     next_state_s;
  logic                             mem_read_valid_r;
  logic                             next_valid_s;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address_r;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] next_address_s;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instruction_r;
  logic [PROGRAM_MEM_DATA_BITS-1:0] next_instruction_s;
  logic [15:0]                      hit_count_r;
  logic [15:0]                      miss_count_r;
  logic                             hit_inc_s;
  logic                             miss_inc_s;
  logic                             fill_s;

  logic [CACHE_LINES-1:0]           line_valid_r;
  logic [TAG_W-1:0]                 line_tag_r    [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] line_data_r   [CACHE_LINES];
  logic                             line_parity_r [CACHE_LINES];

  // Lookup side uses the live PC; fill side uses the latched request address
  // so a PC change during FETCHING cannot redirect the write.
  logic [IDX_W-1:0] lookup_idx_s;
  logic [TAG_W-1:0] lookup_tag_s;
  logic [IDX_W-1:0] fill_idx_s;
  logic [TAG_W-1:0] fill_tag_s;
  logic             lookup_hit_s;

  assign lookup_idx_s = current_pc[IDX_W-1:0];
  assign lookup_tag_s = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_W];
  assign fill_idx_s   = mem_read_address_r[IDX_W-1:0];
  assign fill_tag_s   = mem_read_address_r[PROGRAM_MEM_ADDR_BITS-1:IDX_W];

  // Hit decode reads the pre-flush valid bits, so a flush coincident with a
  // lookup still lets that lookup hit.
  always_comb begin
    lookup_hit_s = 1'b0;
    if (line_valid_r[lookup_idx_s] &&
        (line_tag_r[lookup_idx_s] == lookup_tag_s) &&
        (line_parity_r[lookup_idx_s] ==
         line_parity_f(line_tag_r[lookup_idx_s], line_data_r[lookup_idx_s]))) begin
      lookup_hit_s = 1'b1;
    end else begin
      lookup_hit_s = 1'b0;
    end
  end

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    next_state_s       = state_r;
    next_valid_s       = mem_read_valid_r;
    next_address_s     = mem_read_address_r;
    next_instruction_s = instruction_r;
    hit_inc_s          = 1'b0;
    miss_inc_s         = 1'b0;
    fill_s             = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (lookup_hit_s) begin
            next_state_s       = ST_FETCHED;
            next_instruction_s = line_data_r[lookup_idx_s];
            hit_inc_s          = 1'b1;
          end else begin
            next_state_s   = ST_FETCHING;
            next_valid_s   = 1'b1;
            next_address_s = current_pc;
            miss_inc_s     = 1'b1;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FETCHING: begin
        // core_state is deliberately ignored here: the request always completes.
        if (mem_read_ready) begin
          next_state_s       = ST_FETCHED;
          next_valid_s       = 1'b0;
          next_instruction_s = mem_read_data;
          fill_s             = 1'b1;
        end else begin
          next_state_s = ST_FETCHING;
        end
      end
      ST_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_FETCHED;
        end
      end
      default: begin
        // Unreachable encoding: recover to IDLE with no request outstanding.
        next_state_s = ST_IDLE;
        next_valid_s = 1'b0;
      end
    endcase
  end

  // FSM state, registered outputs and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r            <= ST_IDLE;
      mem_read_valid_r   <= 1'b0;
      mem_read_address_r <= '0;
      instruction_r      <= '0;
      hit_count_r        <= 16'h0000;
      miss_count_r       <= 16'h0000;
    end else begin
      state_r            <= next_state_s;
      mem_read_valid_r   <= next_valid_s;
      mem_read_address_r <= next_address_s;
      instruction_r      <= next_instruction_s;
      if (hit_inc_s && (hit_count_r != 16'hFFFF)) begin
        hit_count_r <= hit_count_r + 16'd1;
      end
      if (miss_inc_s && (miss_count_r != 16'hFFFF)) begin
        miss_count_r <= miss_count_r + 16'd1;
      end
    end
  end

  // Line valid bits: flush has priority over a coincident fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid_r <= '0;
    end else if (flush) begin
      line_valid_r <= '0;
    end else if (fill_s) begin
      line_valid_r[fill_idx_s] <= 1'b1;
    end
  end

  // Line payload: written on every fill; a flushed fill leaves it invalid.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      line_tag_r[fill_idx_s]    <= fill_tag_s;
      line_data_r[fill_idx_s]   <= mem_read_data;
      line_parity_r[fill_idx_s] <= line_parity_f(fill_tag_s, mem_read_data);
    end
  end

  assign fetcher_state    = state_r;
  assign mem_read_valid   = mem_read_valid_r;
  assign mem_read_address = mem_read_address_r;
  assign instruction      = instruction_r;
  assign hit_count        = hit_count_r;
  assign miss_count       = miss_count_r;

endmodule
